// File: rtl/balance_command_controller.sv
`default_nettype none
// ============================================================================
//  Module   : balance_command_controller
//  Purpose  : Fuses filtered accel/gyro pairs into a tilt estimate and a
//             saturated PD motor command with a stale-data watchdog.
//             Optional deadband enabled by defining BALANCE_CMD_DEADBAND_EN.
//  Revision : 1.0  initial release
// ============================================================================
module balance_command_controller #(
  parameter int GYRO_SHIFT     = 4,
  parameter int ACCEL_SHIFT    = 5,
  parameter int BLEND_SHIFT    = 6,
  parameter int KP             = 3,
  parameter int KP_SHIFT       = 6,
  parameter int KD             = 2,
  parameter int KD_SHIFT       = 2,
  parameter int CMD_LIMIT      = 511,
  parameter int TIMEOUT_CYCLES = 2500000
`ifdef BALANCE_CMD_DEADBAND_EN
  ,
  parameter int DEADBAND       = 16
`endif
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [9:0] FAccelX,
  input  logic [9:0] FGyroY,
  input  logic       LowPassDataReady,
  input  logic       HighPassDataReady,
  input  logic       Enable,
  output logic [9:0] PWMinput,
  output logic       CmdValid,
  output logic [15:0] Angle,
  output logic       StaleFault
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_PREDICT = 3'd1;
  localparam logic [2:0] c_ST_CORRECT = 3'd2;
  localparam logic [2:0] c_ST_CONTROL = 3'd3;
  localparam logic [2:0] c_ST_OUTPUT  = 3'd4;

  localparam int c_WD_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES);

  localparam logic signed [25:0] c_KP    = 26'(KP);
  localparam logic signed [25:0] c_KD    = 26'(KD);
  localparam logic signed [25:0] c_LIM26 = 26'(CMD_LIMIT);
  localparam logic signed [9:0]  c_LIM10 = 10'(CMD_LIMIT);
`ifdef BALANCE_CMD_DEADBAND_EN
  localparam logic signed [9:0]  c_DB10  = 10'(DEADBAND);
`endif

  logic [2:0]         state_q, state_d;
  logic               lp_rdy_q, lp_rdy_d, hp_rdy_q, hp_rdy_d;
  logic               aseen_q, aseen_d, gseen_q, gseen_d;
  logic [9:0]         accel_q, accel_d, gyro_q, gyro_d;
  logic [9:0]         accel_w_q, accel_w_d, gyro_w_q, gyro_w_d;
  logic [15:0]        angle_q, angle_d;
  logic signed [25:0] cmd_q, cmd_d;
  logic [9:0]         pwm_q, pwm_d;
  logic               valid_q, valid_d;
  logic               stale_q, stale_d;
  logic [c_WD_W-1:0]  wd_q, wd_d;

  logic               w_accel_rise, w_gyro_rise;
  logic signed [19:0] w_angle_ext, w_gyro_ext, w_accel_ext;
  logic signed [19:0] w_pred_sum, w_corr_sum;
  logic signed [25:0] w_angle26, w_gyro26, w_p_term, w_d_term;
  logic signed [9:0]  w_cmd_sat, w_cmd_out;

  function automatic logic [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sd32767)       return 16'h7FFF;
    else if (v < -20'sd32767) return 16'h8001;
    else                      return v[15:0];
  endfunction

  assign w_accel_rise = LowPassDataReady  & ~lp_rdy_q;
  assign w_gyro_rise  = HighPassDataReady & ~hp_rdy_q;

  assign w_angle_ext = {{4{angle_q[15]}}, angle_q};
  assign w_gyro_ext  = {{10{gyro_w_q[9]}}, gyro_w_q};
  assign w_accel_ext = {{10{accel_w_q[9]}}, accel_w_q};
  assign w_pred_sum  = w_angle_ext + (w_gyro_ext >>> GYRO_SHIFT);
  assign w_corr_sum  = w_angle_ext
                     + (((w_accel_ext <<< ACCEL_SHIFT) - w_angle_ext) >>> BLEND_SHIFT);

  assign w_angle26 = {{10{angle_q[15]}}, angle_q};
  assign w_gyro26  = {{16{gyro_w_q[9]}}, gyro_w_q};
  assign w_p_term  = (w_angle26 * c_KP) >>> KP_SHIFT;
  assign w_d_term  = (w_gyro26 * c_KD) >>> KD_SHIFT;

  always_comb begin
    w_cmd_sat = cmd_q[9:0];
    if (cmd_q > c_LIM26)       w_cmd_sat = c_LIM10;
    else if (cmd_q < -c_LIM26) w_cmd_sat = -c_LIM10;
  end

`ifdef BALANCE_CMD_DEADBAND_EN
  assign w_cmd_out = ((w_cmd_sat < c_DB10) && (w_cmd_sat > -c_DB10)) ? 10'sd0 : w_cmd_sat;
`else
  assign w_cmd_out = w_cmd_sat;
`endif

  always_comb begin
    state_d   = state_q;
    lp_rdy_d  = LowPassDataReady;
    hp_rdy_d  = HighPassDataReady;
    aseen_d   = aseen_q;
    gseen_d   = gseen_q;
    accel_d   = accel_q;
    gyro_d    = gyro_q;
    accel_w_d = accel_w_q;
    gyro_w_d  = gyro_w_q;
    angle_d   = angle_q;
    cmd_d     = cmd_q;
    pwm_d     = pwm_q;
    valid_d   = 1'b0;
    stale_d   = stale_q;
    wd_d      = wd_q;

    case (state_q)
      c_ST_IDLE: begin
        if (aseen_q && gseen_q) begin
          accel_w_d = accel_q;
          gyro_w_d  = gyro_q;
          aseen_d   = 1'b0;
          gseen_d   = 1'b0;
          state_d   = c_ST_PREDICT;
        end
      end
      c_ST_PREDICT: begin
        angle_d = sat16(w_pred_sum);
        state_d = c_ST_CORRECT;
      end
      c_ST_CORRECT: begin
        angle_d = sat16(w_corr_sum);
        state_d = c_ST_CONTROL;
      end
      c_ST_CONTROL: begin
        cmd_d   = w_p_term + w_d_term;
        state_d = c_ST_OUTPUT;
      end
      c_ST_OUTPUT: begin
        pwm_d   = Enable ? w_cmd_out : 10'd0;
        valid_d = 1'b1;
        stale_d = 1'b0;
        state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase

    // A completed command always wins over an expiring watchdog.
    if (state_q == c_ST_OUTPUT) begin
      wd_d = '0;
    end else begin
      if (wd_q >= c_WD_MAX) begin
        stale_d = 1'b1;
        pwm_d   = 10'd0;
      end
      if (wd_q < c_WD_MAX) wd_d = wd_q + c_WD_W'(1);
    end

    // New edges are applied after the IDLE hand-off so they seed the next pair.
    if (w_accel_rise) begin
      accel_d = FAccelX;
      aseen_d = 1'b1;
    end
    if (w_gyro_rise) begin
      gyro_d  = FGyroY;
      gseen_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= c_ST_IDLE;
      lp_rdy_q  <= 1'b0;
      hp_rdy_q  <= 1'b0;
      aseen_q   <= 1'b0;
      gseen_q   <= 1'b0;
      accel_q   <= '0;
      gyro_q    <= '0;
      accel_w_q <= '0;
      gyro_w_q  <= '0;
      angle_q   <= '0;
      cmd_q     <= '0;
      pwm_q     <= '0;
      valid_q   <= 1'b0;
      stale_q   <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lp_rdy_q  <= lp_rdy_d;
      hp_rdy_q  <= hp_rdy_d;
      aseen_q   <= aseen_d;
      gseen_q   <= gseen_d;
      accel_q   <= accel_d;
      gyro_q    <= gyro_d;
      accel_w_q <= accel_w_d;
      gyro_w_q  <= gyro_w_d;
      angle_q   <= angle_d;
      cmd_q     <= cmd_d;
      pwm_q     <= pwm_d;
      valid_q   <= valid_d;
      stale_q   <= stale_d;
      wd_q      <= wd_d;
    end
  end

  assign PWMinput   = pwm_q;
  assign CmdValid   = valid_q;
  assign Angle      = angle_q;
  assign StaleFault = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_balance_command_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_balance_command_controller
//  Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//             against a cycle-scheduled behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_balance_command_controller;

  localparam int c_TO = 100;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] FAccelX = '0, FGyroY = '0;
  logic       LowPassDataReady = 1'b0, HighPassDataReady = 1'b0;
  logic       Enable = 1'b1;
  logic [9:0] PWMinput;
  logic       CmdValid;
  logic [15:0] Angle;
  logic       StaleFault;

  int n_tests = 0;
  int n_fail  = 0;

  balance_command_controller #(.TIMEOUT_CYCLES(c_TO)) dut (
    .CLOCK_50(clk), .RESET(RESET), .FAccelX(FAccelX), .FGyroY(FGyroY),
    .LowPassDataReady(LowPassDataReady), .HighPassDataReady(HighPassDataReady),
    .Enable(Enable), .PWMinput(PWMinput), .CmdValid(CmdValid), .Angle(Angle),
    .StaleFault(StaleFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx10(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int v, input int l);
    if (v > l) return l;
    if (v < -l) return -l;
    return v;
  endfunction

  // Behavioural model: each completed pair is solved with integer arithmetic
  // at launch time and its visible effects are scheduled at fixed offsets.
  int  m_cyc = 0, m_free = 0;
  bit  m_aseen, m_gseen, m_plp, m_php, mon_en = 1'b0;
  int  m_acc, m_gyr, m_angle, m_pwm, m_wd;
  bit  m_valid, m_stale;
  int  t_a1 = -1, t_a2 = -1, t_out = -1, v_a1, v_a2, v_cmd;

  task automatic model_step();
    int c;
    m_cyc++;
    if (RESET) begin
      m_aseen = 0; m_gseen = 0; m_plp = 0; m_php = 0;
      m_acc = 0; m_gyr = 0; m_angle = 0; m_pwm = 0; m_wd = 0;
      m_valid = 0; m_stale = 0;
      t_a1 = -1; t_a2 = -1; t_out = -1;
      m_free = m_cyc + 1;
      mon_en = 1'b1;
    end else begin
      m_valid = 0;
      if (m_cyc == t_a1) m_angle = v_a1;
      if (m_cyc == t_a2) m_angle = v_a2;
      if (m_cyc == t_out) begin
        m_valid = 1; m_pwm = Enable ? v_cmd : 0; m_stale = 0; m_wd = 0;
      end else begin
        if (m_wd >= c_TO) begin m_stale = 1; m_pwm = 0; end
        if (m_wd < c_TO) m_wd++;
      end
      if (m_cyc >= m_free && m_aseen && m_gseen) begin
        v_a1 = sat(m_angle + (m_gyr >>> 4), 32767);
        v_a2 = sat(v_a1 + (((m_acc <<< 5) - v_a1) >>> 6), 32767);
        c = sat(((v_a2 * 3) >>> 6) + ((m_gyr * 2) >>> 2), 511);
`ifdef BALANCE_CMD_DEADBAND_EN
        if (c < 16 && c > -16) c = 0;
`endif
        v_cmd = c;
        t_a1 = m_cyc + 1; t_a2 = m_cyc + 2; t_out = m_cyc + 4; m_free = m_cyc + 5;
        m_aseen = 0; m_gseen = 0;
      end
      if (LowPassDataReady && !m_plp)  begin m_acc = sx10(FAccelX); m_aseen = 1; end
      if (HighPassDataReady && !m_php) begin m_gyr = sx10(FGyroY);  m_gseen = 1; end
      m_plp = LowPassDataReady;
      m_php = HighPassDataReady;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      if (mon_en) begin
        chk("mon_valid", int'(CmdValid), int'(m_valid));
        chk("mon_pwm",   sx10(PWMinput), m_pwm);
        chk("mon_stale", int'(StaleFault), int'(m_stale));
        chk("mon_angle", int'($signed(Angle)), m_angle);
      end
    end
  end

  // Drives one simultaneous pair (edge cycle 0) and returns just after cycle 5.
  task automatic pair(input logic [9:0] a, input logic [9:0] g, input bit chkv);
    FAccelX = a; FGyroY = g; LowPassDataReady = 1; HighPassDataReady = 1;
    @(negedge clk);
    LowPassDataReady = 0; HighPassDataReady = 0;
    repeat (4) @(negedge clk);
    if (chkv) chk("valid_before_5", int'(CmdValid), 0);
    @(negedge clk);
    if (chkv) chk("valid_at_5", int'(CmdValid), 1);
  endtask

  task automatic do_reset();
    RESET = 1;
    repeat (2) @(negedge clk);
    RESET = 0;
  endtask

  bit quiet_lp, quiet_hp;
  int quiet;

  initial begin
    repeat (3) @(negedge clk);
    RESET = 0;
    chk("reset_pwm", sx10(PWMinput), 0);
    chk("reset_valid", int'(CmdValid), 0);
    chk("reset_angle", int'($signed(Angle)), 0);
    chk("reset_stale", int'(StaleFault), 0);

    // Basic pair
    pair(10'd0, 10'd64, 1);
    chk("basic_angle", int'($signed(Angle)), 3);
    chk("basic_pwm", sx10(PWMinput), 32);
    @(negedge clk);
    chk("basic_valid_drop", int'(CmdValid), 0);

    // Staggered pair with accel overwrite
    do_reset();
    FAccelX = 10'd100; LowPassDataReady = 1;
    @(negedge clk); LowPassDataReady = 0;
    repeat (9) @(negedge clk);
    FAccelX = 10'd0; LowPassDataReady = 1;
    @(negedge clk); LowPassDataReady = 0;
    repeat (9) @(negedge clk);
    FGyroY = 10'd64; HighPassDataReady = 1;
    @(negedge clk); HighPassDataReady = 0;
    repeat (4) @(negedge clk);
    chk("stagger_valid_24", int'(CmdValid), 0);
    @(negedge clk);
    chk("stagger_valid_25", int'(CmdValid), 1);
    chk("stagger_pwm", sx10(PWMinput), 32);

    // Saturation, positive then mirrored
    do_reset();
    pair(10'd511, 10'd0, 1);
    chk("sat_first_angle", int'($signed(Angle)), 255);
`ifdef BALANCE_CMD_DEADBAND_EN
    chk("sat_first_pwm", sx10(PWMinput), 0);
`else
    chk("sat_first_pwm", sx10(PWMinput), 11);
`endif
    for (int i = 1; i < 1000; i++) pair(10'd511, 10'd0, 0);
    chk("sat_pos_pwm", sx10(PWMinput), 511);
    do_reset();
    for (int i = 0; i < 1000; i++) pair(10'h201, 10'd0, 0);
    chk("sat_neg_pwm", sx10(PWMinput), -511);
    chk("sat_neg_angle", int'($signed(Angle)), -16352);

    // Watchdog
    do_reset();
    pair(10'd0, 10'd64, 1);
    chk("wd_pwm_before", sx10(PWMinput), 32);
    repeat (100) @(negedge clk);
    chk("wd_stale_100", int'(StaleFault), 0);
    @(negedge clk);
    chk("wd_stale_101", int'(StaleFault), 1);
    chk("wd_pwm_101", sx10(PWMinput), 0);
    chk("wd_angle_held", int'($signed(Angle)), 3);
    pair(10'd0, 10'd64, 1);
    chk("wd_stale_cleared", int'(StaleFault), 0);
    chk("wd_pwm_after", sx10(PWMinput), 32);
    chk("wd_angle_after", int'($signed(Angle)), 6);

    // Enable low
    do_reset();
    Enable = 0;
    pair(10'd0, 10'd64, 1);
    chk("en0_angle", int'($signed(Angle)), 3);
    chk("en0_pwm", sx10(PWMinput), 0);
    Enable = 1;

    // Reset while in CONTROL
    do_reset();
    FAccelX = 10'd0; FGyroY = 10'd64; LowPassDataReady = 1; HighPassDataReady = 1;
    @(negedge clk); LowPassDataReady = 0; HighPassDataReady = 0;
    repeat (3) @(negedge clk);
    RESET = 1;
    @(negedge clk);
    RESET = 0;
    chk("rst_ctl_valid", int'(CmdValid), 0);
    chk("rst_ctl_pwm", sx10(PWMinput), 0);
    chk("rst_ctl_angle", int'($signed(Angle)), 0);
    chk("rst_ctl_stale", int'(StaleFault), 0);
    @(negedge clk);
    chk("rst_ctl_no_valid", int'(CmdValid), 0);
    pair(10'd0, 10'd64, 1);
    chk("rst_ctl_angle2", int'($signed(Angle)), 3);
    chk("rst_ctl_pwm2", sx10(PWMinput), 32);

    // Randomized traffic, checked by the monitor against the model
    quiet = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      FAccelX = 10'($urandom);
      FGyroY  = 10'($urandom);
      RESET   = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) Enable = ~Enable;
      if (quiet == 0 && $urandom_range(0, 149) == 0) quiet = $urandom_range(90, 130);
      if (quiet > 0) begin
        quiet--;
        LowPassDataReady = 0; HighPassDataReady = 0;
      end else begin
        quiet_lp = ($urandom_range(0, 2) == 0);
        quiet_hp = ($urandom_range(0, 2) == 0);
        if (quiet_lp) LowPassDataReady  = ~LowPassDataReady;
        if (quiet_hp) HighPassDataReady = ~HighPassDataReady;
      end
    end
    RESET = 0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/balance_command_controller.md
Name: balance_command_controller

Overview:
- Consumes filtered IMU samples (FAccelX from the low-pass accelerometer filter, FGyroY from the high-pass gyroscope filter) and turns each matched sample pair into a signed 10-bit motor command on PWMinput.
- Fuses the two sensors with a shift-based complementary filter to get a tilt estimate, then applies a PD law.
- Sits between the filter stages and the motor PWMGenerator.
- Includes a stale-data watchdog that forces the motor command to zero.

Parameters:
- GyroShift, 4: gyro-to-angle integration scale (arithmetic right shift).
- AccelShift, 5: accel-to-angle reference scale (left shift).
- BlendShift, 6: complementary blend factor, 1/2^BlendShift per pair.
- Kp, 3: proportional gain (signed constant).
- KpShift, 6: proportional post-shift.
- Kd, 2: derivative gain applied to the gyro rate.
- KdShift, 2: derivative post-shift.
- CmdLimit, 511: output saturation magnitude.
- TimeoutCycles, 2500000: cycles without a command before stale fault (50 ms at 50 MHz).
- Deadband, 16: deadband magnitude, used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- FAccelX  in  10  filtered accelerometer tilt axis, two's complement.
- FGyroY  in  10  filtered gyroscope pitch rate, two's complement.
- LowPassDataReady  in  1  accel sample ready; level or pulse, rising edge is significant.
- HighPassDataReady  in  1  gyro sample ready; rising edge is significant.
- Enable  in  1  motor enable; 0 forces PWMinput to 0.
- PWMinput  out  10  signed motor command.
- CmdValid  out  1  one-cycle pulse, asserted the cycle PWMinput updates.
- Angle  out  16  signed tilt estimate, for debug.
- StaleFault  out  1  high while the watchdog has expired.

Behaviour:
- Single clock CLOCK_50; RESET is synchronous, active-high.
- Reset values: PWMinput=0, CmdValid=0, Angle=0, StaleFault=0, state IDLE, seen-flags cleared, watchdog count 0.
- Reset mid-computation aborts the pair; no CmdValid is produced.
- Edge detect: both ready inputs are registered each cycle. A rising edge latches the matching data register and sets AccelSeen or GyroSeen.
- If a second edge arrives from the same source before the pair completes, it overwrites the data; the flag stays set.
- Simultaneous edges on both inputs latch both.
- State machine:
  - IDLE: when AccelSeen and GyroSeen are both set, copy the data to working registers, clear both flags, go to PREDICT.
  - PREDICT: Angle += sext(Gyro) >>> GyroShift.
  - CORRECT: Angle += ((sext(Accel) <<< AccelShift) - Angle) >>> BlendShift.
  - CONTROL: Cmd = ((Angle*Kp) >>> KpShift) + ((Gyro*Kd) >>> KdShift), in a 26-bit signed intermediate.
  - OUTPUT: saturate Cmd to ±CmdLimit, register PWMinput, pulse CmdValid, return to IDLE.
- Edges arriving during PREDICT..OUTPUT set flags for the next pair; they are never lost.
- Latency: CmdValid is high exactly 5 cycles after the cycle containing the later rising edge (edge cycle = 0).
- Arithmetic:
  - All shifts are arithmetic (floor).
  - Angle update saturates to ±32767.
  - Cmd saturation is symmetric.
- Enable=0: filter and Angle still update and CmdValid still pulses, but PWMinput is written as 0.
- Watchdog:
  - Counter resets to 0 on each OUTPUT; otherwise it increments and saturates.
  - When count reaches TimeoutCycles, StaleFault=1 and PWMinput=0 on the next cycle; Angle is held.
  - The next completed OUTPUT clears StaleFault and writes the new command.

Optional Feature:
- Macro BALANCE_CMD_DEADBAND_EN.
- Defined: in OUTPUT, a saturated Cmd with |Cmd| < Deadband is written as 0. Values at or above Deadband pass unchanged.
- Undefined: no deadband logic and the Deadband parameter is unused.
- Latency is identical in both builds.

Test Plan:
- Basic pair: after reset, FAccelX=0, FGyroY=64, both readies rise together at cycle 0 → Angle=3, PWMinput=32, CmdValid high at cycle 5 only.
- Staggered pair: LowPass edge at cycle 0 with FAccelX=100, LowPass edge at cycle 10 with FAccelX=0, HighPass edge at cycle 20 with FGyroY=64 → single CmdValid at cycle 25, PWMinput=32 (accel overwritten to 0).
- Saturation: FAccelX=511, FGyroY=0, repeated pairs → first pair PWMinput=11 (0 with BALANCE_CMD_DEADBAND_EN); after 1000 pairs PWMinput=511, never exceeds 511; mirror test with -511 gives -511.
- Watchdog (TimeoutCycles=100 in bench): after a CmdValid with PWMinput=32, no readies → StaleFault=1 and PWMinput=0 at cycle 101; next pair clears StaleFault and updates PWMinput.
- Enable=0 with basic-pair stimulus → CmdValid pulses at cycle 5, Angle=3, PWMinput=0.
- RESET asserted in CONTROL state → no CmdValid; next cycle all outputs 0, state IDLE; the next pair behaves as the basic-pair test.
